// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS phase accumulator
// and its sweep controller.
package dds_pkg;

  localparam int ACC_W_DEF     = 28;
  localparam int SW_W_DEF      = 10;
  localparam int OUT_W_DEF     = 12;
  localparam int DWELL_W_DEF   = 16;
  localparam int BASE_TUNE_DEF = 26844;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIXED,
    ST_SWEEP,
    ST_HOLD
  } dds_state_e;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Key press detect, mode FSM and linear sweep stepping
// that produce the current frequency index.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int SW_W       = SW_W_DEF,
  parameter int DWELL_W    = DWELL_W_DEF,
  parameter bit SWEEP_WRAP = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [SW_W-1:0]    sw,
  input  logic               set,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SW_W-1:0]    dec_val,
  output logic               sweeping,
  output logic               sweep_done
);

  dds_state_e         state_q, state_d;
  logic [SW_W-1:0]    dec_q, dec_d;
  logic [SW_W-1:0]    tgt_q, tgt_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] rld_q, rld_d;
  logic               done_q, done_d;
  logic               set_q;
  logic               press;
  logic [DWELL_W-1:0] rld_new;

  assign press   = set_q & ~set;
  assign rld_new = (dwell == '0) ? '0
                 : dwell - DWELL_W'(1);

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (press) begin
      unique case (1'b1)
        (sw == '0): begin
          dec_d   = '0;
          state_d = ST_IDLE;
        end
        (sw != '0 && !mode): begin
          dec_d   = sw;
          state_d = ST_FIXED;
        end
        (sw != '0 && mode): begin
          tgt_d   = sw;
          dec_d   = SW_W'(1);
          rld_d   = rld_new;
          cnt_d   = rld_new;
          state_d = ST_SWEEP;
        end
        default: ;
      endcase
    end else if (state_q == ST_SWEEP) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DWELL_W'(1);
      end else if (dec_q < tgt_q) begin
        dec_d = dec_q + SW_W'(1);
        cnt_d = rld_q;
      end else begin
        done_d = 1'b1;
        if (SWEEP_WRAP) begin
          dec_d = SW_W'(1);
          cnt_d = rld_q;
        end else begin
          state_d = ST_HOLD;
        end
      end
    end
  end

  // set_q follows set during clr so a key held through reset is not a press
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      dec_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
      set_q   <= set;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
      set_q   <= set;
    end
  end

  assign dec_val    = dec_q;
  assign sweeping   = (state_q == ST_SWEEP);
  assign sweep_done = done_q;

endmodule

// File: rtl/dds_phase_accum_sweep.sv
// DDS phase accumulator: tuning word register, accumulator
// and offset phase output feeding the sine LUT.
module dds_phase_accum_sweep
  import dds_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int SW_W       = SW_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int DWELL_W    = DWELL_W_DEF,
  parameter int BASE_TUNE  = BASE_TUNE_DEF,
  parameter bit SWEEP_WRAP = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [SW_W-1:0]    sw,
  input  logic               set,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [OUT_W-1:0]   phase_off,
  output logic [ACC_W-1:0]   fout,
  output logic [OUT_W-1:0]   phase_out,
  output logic [SW_W-1:0]    dec_val,
  output logic               sweeping,
  output logic               sweep_done
  ,
  output logic [ACC_W-1:0]   tuner
);

  logic [SW_W-1:0]  dec;
  logic [ACC_W-1:0] tune_q, tune_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] ph_q, ph_d;

  dds_sweep_ctrl #(
    .SW_W       (SW_W),
    .DWELL_W    (DWELL_W),
    .SWEEP_WRAP (SWEEP_WRAP)
  ) u_ctrl (
    .clk        (clk),
    .clr        (clr),
    .sw         (sw),
    .set        (set),
    .mode       (mode),
    .dwell      (dwell),
    .dec_val    (dec),
    .sweeping   (sweeping),
    .sweep_done (sweep_done)
  );

  // Only the low ACC_W bits of the product survive, so a
  // modulo-2^ACC_W multiply gives the same truncated word.
  assign tune_d = ACC_W'(BASE_TUNE) * ACC_W'(dec);
  assign acc_d  = (tune_q == '0) ? '0 : acc_q + tune_q;
  assign ph_d   = acc_q[ACC_W-1 -: OUT_W] + phase_off;

  always_ff @(posedge clk) begin
    if (clr) begin
      tune_q <= '0;
      acc_q  <= '0;
      ph_q   <= '0;
    end else begin
      tune_q <= tune_d;
      acc_q  <= acc_d;
      ph_q   <= ph_d;
    end
  end

  assign fout      = acc_q;
  assign phase_out = ph_q;
  assign dec_val   = dec;
  assign tuner     = tune_q;

endmodule

// File: tb/tb_dds_phase_accum_sweep.sv
// Directed bench for dds_phase_accum_sweep: fixed tune,
// phase offset, sweep with/without wrap, reset mid-sweep.
module tb_dds_phase_accum_sweep;

  localparam int TW = 268440;
  localparam int MASK28 = 32'h0FFF_FFFF;

  logic        clk = 1'b0;
  logic        clr;
  logic [9:0]  sw;
  logic        set;
  logic        mode;
  logic [15:0] dwell;
  logic [11:0] phase_off;

  logic [27:0] fout, fout_w, tuner, tuner_w;
  logic [11:0] ph, ph_w;
  logic [9:0]  dec, dec_w;
  logic        swp, swp_w, done, done_w;

  int n_tests = 0;
  int n_fail  = 0;

  int seq_nw[9] = '{1, 1, 2, 2, 3, 3, 3, 3, 3};
  int seq_w[9]  = '{1, 1, 2, 2, 3, 3, 1, 1, 2};
  int seq0_nw[6] = '{1, 2, 3, 3, 3, 3};
  int seq0_w[6]  = '{1, 2, 3, 1, 2, 3};

  always #5 clk = ~clk;

  dds_phase_accum_sweep #(.SWEEP_WRAP(1'b0)) dut (
    .clk        (clk),
    .clr        (clr),
    .sw         (sw),
    .set        (set),
    .mode       (mode),
    .dwell      (dwell),
    .phase_off  (phase_off),
    .fout       (fout),
    .phase_out  (ph),
    .dec_val    (dec),
    .sweeping   (swp),
    .sweep_done (done),
    .tuner      (tuner)
  );

  dds_phase_accum_sweep #(.SWEEP_WRAP(1'b1)) dut_w (
    .clk        (clk),
    .clr        (clr),
    .sw         (sw),
    .set        (set),
    .mode       (mode),
    .dwell      (dwell),
    .phase_off  (phase_off),
    .fout       (fout_w),
    .phase_out  (ph_w),
    .dec_val    (dec_w),
    .sweeping   (swp_w),
    .sweep_done (done_w),
    .tuner      (tuner_w)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_f, prev, np_w, np_nw;
    bit wrapped;
    clr = 1'b1; set = 1'b1; mode = 1'b0;
    sw = '0; dwell = '0; phase_off = '0;
    tick(); tick();
    chk("rst_fout", 32'(fout), 0);
    chk("rst_ph", 32'(ph), 0);
    chk("rst_dec", 32'(dec), 0);
    chk("rst_tuner", 32'(tuner), 0);
    chk("rst_swp", 32'(swp), 0);
    chk("rst_done", 32'(done), 0);
    clr = 1'b0;
    tick();

    // fixed frequency, index 10
    sw = 10; set = 1'b0;
    tick();
    chk("fix_dec", 32'(dec), 10);
    chk("fix_tun0", 32'(tuner), 0);
    chk("fix_swp", 32'(swp), 0);
    set = 1'b1;
    tick();
    chk("fix_tun1", 32'(tuner), TW);
    chk("fix_f1", 32'(fout), 0);
    tick();
    chk("fix_f2", 32'(fout), TW);
    tick();
    chk("fix_f3", 32'(fout), 536880);
    chk("fix_ph3", 32'(ph), 4);
    phase_off = 12'd2048;
    tick();
    chk("fix_f4", 32'(fout), 805320);
    chk("off_ph4", 32'(ph), 2056);
    exp_f = 805320;
    wrapped = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      prev  = exp_f;
      exp_f = (exp_f + TW) & MASK28;
      if (exp_f < prev) wrapped = 1'b1;
      tick();
      chk("acc_f", 32'(fout), exp_f);
      chk("acc_ph", 32'(ph), ((prev >> 16) + 2048) & 4095);
    end
    chk("acc_wrap", 32'(wrapped), 1);

    // press with sw=0 stops the accumulator
    sw = 0; set = 1'b0;
    tick();
    chk("stop_dec", 32'(dec), 0);
    chk("stop_tun0", 32'(tuner), TW);
    set = 1'b1;
    tick();
    chk("stop_tun1", 32'(tuner), 0);
    tick();
    chk("stop_f2", 32'(fout), 0);
    tick();
    chk("stop_f3", 32'(fout), 0);
    chk("stop_ph", 32'(ph), 2048);
    phase_off = '0;

    // sweep to 3 with dwell 2
    sw = 3; mode = 1'b1; dwell = 2; set = 1'b0;
    tick();
    set = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk("swp_dec", 32'(dec), seq_nw[i]);
      chk("swpw_dec", 32'(dec_w), seq_w[i]);
      chk("swp_done", 32'(done), (i == 6) ? 1 : 0);
      chk("swpw_done", 32'(done_w), (i == 6) ? 1 : 0);
      chk("swp_busy", 32'(swp), (i < 6) ? 1 : 0);
      chk("swpw_busy", 32'(swp_w), 1);
    end
    np_w = 0; np_nw = 0;
    for (int i = 9; i <= 20; i++) begin
      tick();
      np_w  += int'(done_w);
      np_nw += int'(done);
    end
    chk("wrap_pulses", 32'(np_w), 2);
    chk("hold_pulses", 32'(np_nw), 0);
    chk("hold_dec", 32'(dec), 3);
    chk("hold_tun", 32'(tuner), 80532);

    // dwell 0 behaves as 1
    dwell = 0; set = 1'b0;
    tick();
    set = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk("d0_dec", 32'(dec), seq0_nw[i]);
      chk("d0w_dec", 32'(dec_w), seq0_w[i]);
      chk("d0_done", 32'(done), (i == 3) ? 1 : 0);
    end

    // clr mid-sweep with set held low
    dwell = 2; set = 1'b0;
    tick(); tick(); tick();
    chk("held_dec", 32'(dec), 2);
    clr = 1'b1;
    tick();
    chk("clr_fout", 32'(fout), 0);
    chk("clr_ph", 32'(ph), 0);
    chk("clr_dec", 32'(dec), 0);
    chk("clr_tun", 32'(tuner), 0);
    chk("clr_swp", 32'(swp), 0);
    chk("clr_decw", 32'(dec_w), 0);
    clr = 1'b0;
    tick(); tick();
    chk("nopress_dec", 32'(dec), 0);
    chk("nopress_swp", 32'(swp), 0);
    set = 1'b1;
    tick();
    set = 1'b0;
    tick();
    chk("repress_dec", 32'(dec), 1);
    chk("repress_swp", 32'(swp), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
